// File: rtl/affine_sequencer.sv
// affine_sequencer
//   Multi-cycle controller for the picoMIPS affine-transform datapath.
//   Computes xo = a11*x + a12*y + b1 and yo = a21*x + a22*y + b2. One shared
//   multiplier and one shared adder are used, with one operation per cycle
//   over the sequence M1 M2 A1 A2 M3 M4 A3 A4, followed by DONE.
//
//   Ports
//     clk        system clock, rising edge
//     reset      asynchronous, active-high reset
//     in_valid   operand set presented
//     in_ready   block can accept an operand set (IDLE only)
//     x, y       signed input point (N bits)
//     a11..a22   signed Q1.(N-1) matrix coefficients
//     b1, b2     signed translation
//     out_valid  xo/yo hold a finished result (DONE)
//     out_ready  consumer accepts the result
//     xo, yo     signed transformed point
//     busy       high in every state except IDLE
module affine_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] a11,
  input  logic [N-1:0] a12,
  input  logic [N-1:0] a21,
  input  logic [N-1:0] a22,
  input  logic [N-1:0] b1,
  input  logic [N-1:0] b2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] xo,
  output logic [N-1:0] yo,
  output logic         busy
);

  typedef enum logic [3:0] {
    IDLE, M1, M2, A1, A2, M3, M4, A3, A4, DONE
  } state_t;

  state_t state_reg, state_next;

  // Captured operands
  logic [N-1:0] x_reg, y_reg;
  logic [N-1:0] a11_reg, a12_reg, a21_reg, a22_reg;
  logic [N-1:0] b1_reg, b2_reg;

  // Partial products and partial sum
  logic [N-1:0] p_reg, q_reg, s_reg;

  // Shared ALU
  logic [N-1:0]   mul_a, mul_b;
  logic [2*N-1:0] prod;
  logic [N-1:0]   mul_res;
  logic [N-1:0]   add_a, add_b;
  logic [N-1:0]   add_res;
  logic           prod_unused;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = M1;
      end
      M1:   state_next = M2;
      M2:   state_next = A1;
      A1:   state_next = A2;
      A2:   state_next = M3;
      M3:   state_next = M4;
      M4:   state_next = A3;
      A3:   state_next = A4;
      A4:   state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand selection for the shared multiplier and adder
  always_comb begin
    mul_a = a11_reg;
    mul_b = x_reg;
    add_a = s_reg;
    add_b = b1_reg;
    case (state_reg)
      M2: begin mul_a = a12_reg; mul_b = y_reg; end
      M3: begin mul_a = a21_reg; mul_b = x_reg; end
      M4: begin mul_a = a22_reg; mul_b = y_reg; end
      A1, A3: begin add_a = p_reg; add_b = q_reg; end
      A4: begin add_a = s_reg; add_b = b2_reg; end
      default: ;
    endcase
  end

  // Sign-extend both operands to 2N bits so the low 2N bits of the unsigned
  // product equal the signed product. Taking bits [2N-2:N-1] is an arithmetic
  // shift right by N-1 (floor), and dropping the top bit wraps on overflow.
  assign prod        = {{N{mul_a[N-1]}}, mul_a} * {{N{mul_b[N-1]}}, mul_b};
  assign mul_res     = prod[2*N-2:N-1];
  assign prod_unused = &{1'b0, prod[2*N-1], prod[N-2:0]};
  assign add_res     = add_a + add_b;

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg   <= '0;
      y_reg   <= '0;
      a11_reg <= '0;
      a12_reg <= '0;
      a21_reg <= '0;
      a22_reg <= '0;
      b1_reg  <= '0;
      b2_reg  <= '0;
      p_reg   <= '0;
      q_reg   <= '0;
      s_reg   <= '0;
      xo      <= '0;
      yo      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg   <= x;
            y_reg   <= y;
            a11_reg <= a11;
            a12_reg <= a12;
            a21_reg <= a21;
            a22_reg <= a22;
            b1_reg  <= b1;
            b2_reg  <= b2;
          end
        end
        M1, M3: p_reg <= mul_res;
        M2, M4: q_reg <= mul_res;
        A1, A3: s_reg <= add_res;
        A2:     xo    <= add_res;
        A4:     yo    <= add_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_affine_sequencer.sv
// Testbench for affine_sequencer: directed cases plus randomized
// transactions, checked by a scoreboard against an arithmetic reference model.
module tb_affine_sequencer;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x, y, a11, a12, a21, a22, b1, b2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] xo, yo;
  logic         busy;

  affine_sequencer #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .a11      (a11),
    .a12      (a12),
    .a21      (a21),
    .a22      (a22),
    .b1       (b1),
    .b2       (b2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xo       (xo),
    .yo       (yo),
    .busy     (busy)
  );

  typedef struct {
    logic [7:0] x, y, a11, a12, a21, a22, b1, b2;
  } op_t;

  typedef struct {
    logic [7:0] xo, yo;
    int         acc;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   txn_id = 0;
  bit   rand_ready = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model: real-valued Q1.7 coefficient times integer, floored,
  // then everything reduced modulo 256.
  function automatic int sx(input logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  function automatic int fmul(input logic [7:0] coef, input logic [7:0] v);
    int p, q;
    p = sx(coef) * sx(v);
    q = p / 128;
    if (p < 0 && (p % 128) != 0) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(input op_t o, input int acc);
    exp_t e;
    int rx, ry;
    rx = (fmul(o.a11, o.x) + fmul(o.a12, o.y) + sx(o.b1)) & 255;
    ry = (fmul(o.a21, o.x) + fmul(o.a22, o.y) + sx(o.b2)) & 255;
    e.xo  = rx[7:0];
    e.yo  = ry[7:0];
    e.acc = acc;
    e.id  = 0;
    return e;
  endfunction

  function automatic op_t mk(input logic [7:0] px, py, pa11, pa12, pb1, pa21, pa22, pb2);
    op_t o;
    o.x = px; o.y = py; o.a11 = pa11; o.a12 = pa12; o.b1 = pb1;
    o.a21 = pa21; o.a22 = pa22; o.b2 = pb2;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.x = 8'($urandom); o.y = 8'($urandom);
    o.a11 = 8'($urandom); o.a12 = 8'($urandom);
    o.a21 = 8'($urandom); o.a22 = 8'($urandom);
    o.b1 = 8'($urandom); o.b2 = 8'($urandom);
    return o;
  endfunction

  task automatic drive_ops(input op_t o);
    x = o.x; y = o.y; a11 = o.a11; a12 = o.a12;
    a21 = o.a21; a22 = o.a22; b1 = o.b1; b2 = o.b2;
  endtask

  // Present an operand set, wait for acceptance, push the expected result.
  task automatic send(input op_t o, input bit keep, output int acc);
    exp_t e;
    bit ok;
    ok  = 0;
    acc = -1;
    @(negedge clk);
    drive_ops(o);
    in_valid = 1;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
    end else begin
      acc = cycle + 1;
      e = model(o, acc);
      txn_id++;
      e.id = txn_id;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (!keep) in_valid = 0;
    end
  endtask

  // Monitor: pops on each rising out_valid, checks latency and stability.
  logic       prev_valid = 0;
  logic [7:0] prev_xo, prev_yo;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_valid = 0;
    end else if (out_valid) begin
      chk("done_in_ready", int'(in_ready), 0);
      chk("done_busy", int'(busy), 1);
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("xo", int'(xo), int'(e.xo));
          chk("yo", int'(yo), int'(e.yo));
          chk("latency", cycle - e.acc, 8);
          $display("txn %0d xo=0x%0h yo=0x%0h exp_xo=0x%0h exp_yo=0x%0h lat=%0d",
                   e.id, xo, yo, e.xo, e.yo, cycle - e.acc);
        end
      end else begin
        chk("xo_stable", int'(xo), int'(prev_xo));
        chk("yo_stable", int'(yo), int'(prev_yo));
      end
      prev_valid = 1;
      prev_xo = xo;
      prev_yo = yo;
    end else begin
      prev_valid = 0;
    end
  end

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_xo"}, int'(xo), 0);
    chk({tag, "_yo"}, int'(yo), 0);
  endtask

  initial begin
    int acc1, acc2, dummy;
    op_t o;
    reset = 1; in_valid = 0; out_ready = 1;
    drive_ops(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check_reset_outputs("reset");
    #20 reset = 0;

    // Nominal point
    send(mk(8'd20, 8'd40, 8'h40, 8'h40, 8'd5, 8'h7F, 8'hC0, 8'd3), 0, dummy);
    wait_valid();
    // Add wrap
    send(mk(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'd0, 8'h00, 8'h00, 8'd0), 0, dummy);
    wait_valid();
    // Floor and overflow
    send(mk(8'hFD, 8'h00, 8'h40, 8'h00, 8'd0, 8'h80, 8'h00, 8'd0), 0, dummy);
    wait_valid();
    send(mk(8'h80, 8'h00, 8'h00, 8'h00, 8'd0, 8'h80, 8'h00, 8'd0), 0, dummy);
    wait_valid();

    // Output backpressure with in_valid toggling garbage
    @(negedge clk);
    out_ready = 0;
    send(rnd_op(), 0, dummy);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      drive_ops(rnd_op());
      in_valid = ~in_valid;
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    chk("bp_idle_in_ready", int'(in_ready), 1);
    chk("bp_idle_out_valid", int'(out_valid), 0);
    send(rnd_op(), 0, dummy);
    wait_valid();

    // Reset asserted between edges while in M4
    send(rnd_op(), 0, acc1);
    repeat (5) @(posedge clk);
    #3 reset = 1;
    #1;
    check_reset_outputs("midop");
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #2 reset = 0;
    send(rnd_op(), 0, dummy);
    wait_valid();

    // Back-to-back with in_valid and out_ready held high
    @(negedge clk);
    out_ready = 1;
    send(rnd_op(), 1, acc1);
    send(rnd_op(), 0, acc2);
    chk("b2b_accept_gap", acc2 - acc1, 10);
    wait_valid();

    // Randomized transactions with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 20; i++) begin
      send(rnd_op(), 0, dummy);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    rand_ready = 0;
    out_ready = 1;
    chk("scoreboard_empty", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/affine_sequencer.md
Name: affine_sequencer

Overview:
- Multi-cycle controller for the picoMIPS affine-transform datapath. Computes xo = a11*x + a12*y + b1 and yo = a21*x + a22*y + b2.
- Works as the issuing and collecting end of the ALU operand/result interface. Sequences 4 multiplies and 4 adds through one shared time-multiplexed ALU datapath, one operation per cycle.
- Uses valid/ready handshakes on the input side and the output side.

Parameters:
- N, 8, datapath width in bits. Coordinates and translations are signed integers. Matrix coefficients are signed Q1.(N-1) fractions.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept an operand set (IDLE only)
- x, y  input  N each  signed input point
- a11, a12, a21, a22  input  N each  signed Q1.(N-1) coefficients
- b1, b2  input  N each  signed translation
- out_valid  output  1  xo/yo hold the result
- out_ready  input  1  consumer accepts the result
- xo, yo  output  N each  signed transformed point
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset state:
  - Reset is asynchronous and active-high: reset forces IDLE immediately.
  - Outputs in reset: in_ready=1, out_valid=0, busy=0, xo=0, yo=0.
  - All internal operand and partial-sum registers clear to 0.
- States, in order: IDLE, M1, M2, A1, A2, M3, M4, A3, A4, DONE. Each compute state lasts exactly one cycle.
- Accept:
  - In IDLE, in_valid&&in_ready at a rising edge registers all 8 operands and moves to M1.
  - Operand inputs are don't-care after acceptance.
- Compute steps (p, q, s are internal registers):
  - M1: p=a11*x
  - M2: q=a12*y
  - A1: s=p+q
  - A2: xo=s+b1
  - M3: p=a21*x
  - M4: q=a22*y
  - A3: s=p+q
  - A4: yo=s+b2, then DONE
- Multiply rule:
  - Full 2N-bit signed product; result is product[2N-2:N-1].
  - This is an arithmetic right shift by N-1, rounding toward minus infinity.
  - Overflow wraps, with no saturation: (-128)*(-128) gives 0x80 for N=8.
- Add rule: (a+b) mod 2^N, two's complement wrap, no saturation or overflow flag.
- Latency: if acceptance is at edge k, out_valid is high after edge k+8.
- DONE:
  - out_valid=1, in_ready=0, busy=1.
  - xo/yo stay stable until out_ready is sampled high.
  - Then the next edge returns to IDLE: out_valid=0, in_ready=1.
  - xo/yo keep the last result, but are only meaningful while out_valid=1.
- Throughput: no overlap. A new operand set is accepted at earliest on the edge after the DONE->IDLE transition. in_valid during DONE is ignored, even if out_ready is high in the same cycle.
- Intermediate visibility: xo updates at A2, before out_valid is asserted. The consumer must qualify xo/yo with out_valid.
- Reset mid-operation: any state goes immediately to reset values. A partially computed result is discarded, and no out_valid pulse is produced.
- in_valid in any non-IDLE state: ignored, with no effect on the sequence.
- out_ready outside DONE: ignored.

Test Plan:
- Nominal point:
  - Stimulus: reset, then present x=20, y=40, a11=0x40, a12=0x40, b1=5, a21=0x7F, a22=0xC0, b2=3.
  - Required: out_valid rises 8 edges after acceptance, with xo=35 and yo=2 (19 + -20 + 3).
- Add wrap:
  - Stimulus: a11=a12=0x7F, x=y=0x7F, b1=0, other coefficients 0.
  - Required: xo=0xFC (126+126 wraps to -4), yo=0.
- Floor and overflow:
  - Stimulus: a11=0x40, x=-3, a12=0, b1=0; a21=0x80, x=-3.
  - Required: xo=0xFE (-2).
  - Separate run: a21=0x80, x=0x80, a22=0, b2=0 gives yo=0x80.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises, and toggle in_valid with new operands throughout.
  - Required: out_valid, xo and yo stay stable and no new operands are accepted. After out_ready=1, IDLE follows one edge later and the next set is accepted.
- Reset mid-op:
  - Stimulus: assert reset asynchronously (between edges) while in M4.
  - Required: in_ready=1, out_valid=0, busy=0, xo=yo=0 immediately. A following transaction computes correctly from fresh operands.
- Back-to-back:
  - Stimulus: two transactions with in_valid held high and out_ready held high.
  - Required: second acceptance occurs exactly 1 edge after the DONE->IDLE edge, and both results are correct.
